// File: rtl/bayer_gray_decim.sv
// rtl/bayer_gray_decim.sv - RGGB Bayer to grayscale with 2x2 decimation, one-line buffer.
// Optional luma weighting with `define GRAY_LUMA_WEIGHT_EN; plain 4-pixel average otherwise.
module bayer_gray_decim #(
    parameter int DATA_W  = 12,
    parameter int LINE_W  = 1280,
    parameter int FRAME_H = 960,
    localparam int OXW = $clog2(LINE_W / 2),
    localparam int OYW = ($clog2(FRAME_H / 2) < 1) ? 1 : $clog2(FRAME_H / 2)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_sof,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic [OXW-1:0]    out_x,
    output logic [OYW-1:0]    out_y,
    output logic              out_eol,
    output logic              out_eof,
    output logic              busy
);

    localparam int XW = $clog2(LINE_W);
    localparam int YW = $clog2(FRAME_H);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        COMP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] lb [LINE_W];

    logic              lb_we;
    logic [XW-1:0]     lb_waddr;
    logic              hold_we;
    logic              fire;
    logic              last_x;
    logic              last_y;
    logic [DATA_W-1:0] pix_r;
    logic [DATA_W-1:0] pix_g1;
    logic [DATA_W-1:0] gray;

    assign last_x = (x_q == XW'(LINE_W - 1));
    assign last_y = (y_q == YW'(FRAME_H - 1));
    assign busy   = (state_q != IDLE);

    // Even row of the quad lives in the line buffer; x is odd whenever they are read.
    assign pix_r  = lb[{x_q[XW-1:1], 1'b0}];
    assign pix_g1 = lb[x_q];

`ifdef GRAY_LUMA_WEIGHT_EN
    localparam int SW = DATA_W + 8;
    logic [SW-1:0] sum;
    assign sum  = SW'(77) * SW'(pix_r)
                + SW'(75) * (SW'(pix_g1) + SW'(hold_q))
                + SW'(29) * SW'(in_data);
    assign gray = sum[SW-1:8];
`else
    localparam int SW = DATA_W + 2;
    logic [SW-1:0] sum;
    assign sum  = SW'(pix_r) + SW'(pix_g1) + SW'(hold_q) + SW'(in_data);
    assign gray = sum[SW-1:2];
`endif

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        lb_we    = 1'b0;
        lb_waddr = x_q;
        hold_we  = 1'b0;
        fire     = 1'b0;
        if (in_valid) begin
            if (in_sof) begin
                // Start of frame from any state; a partial quad is simply dropped.
                state_d  = FILL;
                x_d      = XW'(1);
                y_d      = '0;
                lb_we    = 1'b1;
                lb_waddr = '0;
            end else if (state_q != IDLE) begin
                if (last_x) begin
                    x_d = '0;
                    y_d = last_y ? '0 : y_q + YW'(1);
                end else begin
                    x_d = x_q + XW'(1);
                end
                if (state_q == FILL) begin
                    lb_we = 1'b1;
                    if (last_x) begin
                        state_d = COMP;
                    end
                end else begin
                    hold_we = 1'b1;
                    fire    = x_q[0];
                    if (last_x) begin
                        state_d = last_y ? IDLE : FILL;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            if (hold_we) begin
                hold_q <= in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (lb_we) begin
            lb[lb_waddr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else begin
            out_valid <= fire;
            if (fire) begin
                out_data <= gray;
                out_x    <= OXW'(x_q >> 1);
                out_y    <= OYW'(y_q >> 1);
                out_eol  <= last_x;
                out_eof  <= last_x & last_y;
            end
        end
    end

endmodule

// File: doc/bayer_gray_decim.md
Name: bayer_gray_decim

Overview:
Parametrised Bayer-to-grayscale converter with 2x2 decimation. It sits between the camera data-capture stage and the SDRAM write FIFO. Each 2x2 Bayer quad (RGGB, quad origin at even x, even y) becomes one grayscale pixel, so a LINE_W x FRAME_H raw frame produces a (LINE_W/2) x (FRAME_H/2) gray frame. The block has an internal one-line buffer, an explicit frame state machine and output coordinates/markers for downstream address generation.

Parameters:
DATA_W, 12, width of raw and gray pixels.
LINE_W, 1280, raw pixels per line. Must be even and >= 4.
FRAME_H, 960, raw lines per frame. Must be even and >= 2.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_data  in  DATA_W  raw Bayer pixel
in_valid  in  1  in_data qualifier, one pixel per cycle when high
in_sof  in  1  start of frame, valid only with in_valid; marks pixel (0,0)
out_data  out  DATA_W  gray pixel
out_valid  out  1  out_data/out_x/out_y/out_eol/out_eof qualifier, 1-cycle pulse
out_x  out  $clog2(LINE_W/2)  gray column
out_y  out  $clog2(FRAME_H/2)  gray row
out_eol  out  1  last gray pixel of a gray row
out_eof  out  1  last gray pixel of the frame
busy  out  1  high in FILL or COMP

Behaviour:
- Reset: rst_n is asynchronous and active-low; the block is clocked on clk. During reset all outputs, the x/y counters, the held pixel and the state register go to 0, and the state is IDLE. Line-buffer RAM contents are not reset.
- Counters: x (0..LINE_W-1) and y (0..FRAME_H-1) advance only on in_valid. x wraps to 0 at LINE_W-1 and y increments at the same time. Gaps in in_valid stall the counters with no side effects.
- States:
  - IDLE: in_valid without in_sof is ignored. in_valid & in_sof: the pixel is taken as (0,0), x becomes 1, y becomes 0, and the next state is FILL.
  - FILL (y even): each valid pixel is written to lb[x]. When the last pixel of the row is accepted, the next state is COMP.
  - COMP (y odd): each valid pixel is registered into hold.
    - At odd x, compute sum = lb[x-1] + lb[x] + hold + in_data.
    - The sum is DATA_W+2 bits wide. out_data = sum >> 2 (truncated).
    - At the last pixel of the row: if y == FRAME_H-1, go to IDLE; otherwise go to FILL.
- in_sof with in_valid while in FILL or COMP restarts the frame. That pixel becomes (0,0), any partial quad is discarded and the state is FILL. No out_eof is produced for the aborted frame.
- Output timing:
  - out_valid rises exactly 1 cycle after the in_valid beat carrying the odd-x, odd-y pixel. All outputs are registered.
  - out_x = x>>1 and out_y = y>>1, both sampled at that same beat.
  - out_eol = (out_x == LINE_W/2-1). out_eof = out_eol & (out_y == FRAME_H/2-1).
  - out_data/out_x/out_y hold their values between pulses. out_eol/out_eof are only meaningful with out_valid.
- busy = (state != IDLE).
- There is no backpressure: the downstream FIFO must accept one pixel per 2 input beats.
- Line-buffer read and write of lb[x] never conflict, because FILL only writes and COMP only reads.

Optional Feature:
- Macro GRAY_LUMA_WEIGHT_EN.
- Defined: luma weighting replaces the plain average.
  - Terms: R = lb[x-1], G1 = lb[x], G2 = hold, B = in_data.
  - sum = 77*R + 75*(G1+G2) + 29*B, computed at DATA_W+8 bits.
  - out_data = sum >> 8 (truncated). Latency remains 1 cycle.
- Undefined: plain 4-pixel average as described in Behaviour; no multipliers are synthesised.

Test Plan:
- Basic average, LINE_W=4, FRAME_H=2. Stimulus: row0 100,200,300,400 (sof on 100); row1 500,600,700,800, back-to-back. Response: out_valid pulses with 350 (x0,y0) then 550 (x1,y0, eol=1, eof=1). busy returns to 0 after the last pixel.
- Valid gaps: same data with in_valid toggling 1-0-0-1. Response: identical out_data values; each out_valid comes 1 cycle after the 4th pixel of its quad.
- IDLE filter and mid-frame restart:
  - Pixels sent without sof while in IDLE produce no output.
  - sof inserted at row1 x=2 restarts the frame; only the quads of the new frame are output, and no eof is produced for the old frame.
- Async reset: assert rst_n low mid-row1. Response: all outputs read 0 immediately and the state is IDLE. The next sof frame is correct.
- Full-scale: all pixels 4095, LINE_W=8, FRAME_H=4. Response: 8 outputs, each 4095, with eol at out_x=3 and eof on the last.
- GRAY_LUMA_WEIGHT_EN: the basic-average frame gives 303 and 503.
